// File: rtl/pr_bus_pkg.sv
// Shared bridge-bus definitions: size codes, master FSM states, command record, lane helpers.
// Latency: none, the helpers are purely combinational.
// Backpressure: none here; users of the package own their handshakes.
// Build macro PR_BUS_MASTER_POLL_EN adds the poll fields to cmd_t.
package pr_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } sz_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // One buffered command as it sits in the FIFO.
  typedef struct packed {
`ifdef PR_BUS_MASTER_POLL_EN
    logic        poll;
    logic [31:0] mask;
`endif
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Access cannot be placed on the bus: unaligned half/word or reserved size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Copy the right-aligned write data onto every lane it could target.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and zero-extend.
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {lane, 3'b000};
    case (size)
      SZ_BYTE: return {24'h0, sh[7:0]};
      SZ_HALF: return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/pr_bus_master_if.sv
// Command, response and bridge-bus signals of the bus master, bundled for port lists.
// Latency: wires only.
// Backpressure: cmd valid/ready and rsp valid/ready; the bridge side has no stall.
// Build macro PR_BUS_MASTER_POLL_EN adds cmd_poll/cmd_mask.
interface pr_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
`ifdef PR_BUS_MASTER_POLL_EN
  logic        cmd_poll;
  logic [31:0] cmd_mask;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PrAddr;
  logic [3:0]  BE;
  logic [31:0] PrWD;
  logic        Wr;
  logic [31:0] PrRD;

  // The bus master itself.
  modport master (
`ifdef PR_BUS_MASTER_POLL_EN
    input  cmd_poll, cmd_mask,
`endif
    input  cmd_valid, cmd_wr, cmd_size, cmd_addr, cmd_wdata, rsp_ready, PrRD,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PrAddr, BE, PrWD, Wr
  );

  // Whoever issues commands, consumes responses and models the bridge.
  modport slave (
`ifdef PR_BUS_MASTER_POLL_EN
    output cmd_poll, cmd_mask,
`endif
    output cmd_valid, cmd_wr, cmd_size, cmd_addr, cmd_wdata, rsp_ready, PrRD,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PrAddr, BE, PrWD, Wr
  );
endinterface

// File: rtl/pr_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count, full/empty flags and show-ahead output.
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; push+pop together is legal.
module pr_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty/count guard every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/pr_bus_master.sv
// Bridge-bus initiator: buffers byte/half/word commands and replays them as single-cycle bridge accesses.
// Latency: accept in cycle N -> bus access N+2 -> rsp_valid N+3; RESP->ISSUE without a bubble.
// Backpressure: cmd_ready drops while the FIFO is full; an unaccepted response holds the FSM in RESP.
// Build macro PR_BUS_MASTER_POLL_EN: read-poll commands with mask/compare and POLL_MAX timeout.
module pr_bus_master
  import pr_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
`ifdef PR_BUS_MASTER_POLL_EN
  , parameter int POLL_MAX = 1024
`endif
) (
  input  logic            clk,
  input  logic            RST,
  pr_bus_master_if.master bus,
  output logic            busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cmd_t          fifo_din, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, load;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rd_lane;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] praddr_q, praddr_d, prwd_q, prwd_d;
  logic        rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        cur_wr_q, cur_wr_d, cur_err_q, cur_err_d;
  logic [1:0]  cur_size_q, cur_size_d, cur_lane_q, cur_lane_d;
`ifdef PR_BUS_MASTER_POLL_EN
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  logic          cur_poll_q, cur_poll_d, poll_hit, poll_last;
  logic [31:0]   cur_mask_q, cur_mask_d, cur_val_q, cur_val_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
`endif

  assign bus.cmd_ready = RST && !fifo_full;
  assign fifo_push     = bus.cmd_valid && bus.cmd_ready;
  assign fifo_din.wr    = bus.cmd_wr;
  assign fifo_din.size  = bus.cmd_size;
  assign fifo_din.addr  = bus.cmd_addr;
  assign fifo_din.wdata = bus.cmd_wdata;
`ifdef PR_BUS_MASTER_POLL_EN
  assign fifo_din.poll  = bus.cmd_poll;
  assign fifo_din.mask  = bus.cmd_mask;
  assign poll_hit  = (rd_lane & cur_mask_q) == (cur_val_q & cur_mask_q);
  assign poll_last = poll_cnt_q == PW'(POLL_MAX - 1);
`endif

  pr_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (RST),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_lane       = lane_extract(cur_size_q, cur_lane_q, bus.PrRD);
  assign bus.PrAddr    = praddr_q;
  assign bus.BE        = be_q;
  assign bus.PrWD      = prwd_q;
  assign bus.Wr        = wr_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

  // FSM next state; bus strobes default low so they only live for ISSUE cycles.
  always_comb begin
    state_d     = state_q;
    wr_d        = 1'b0;
    be_d        = 4'b0000;
    praddr_d    = praddr_q;
    prwd_d      = prwd_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cur_wr_d    = cur_wr_q;
    cur_err_d   = cur_err_q;
    cur_size_d  = cur_size_q;
    cur_lane_d  = cur_lane_q;
`ifdef PR_BUS_MASTER_POLL_EN
    cur_poll_d  = cur_poll_q;
    cur_mask_d  = cur_mask_q;
    cur_val_d   = cur_val_q;
    poll_cnt_d  = poll_cnt_q;
`endif
    fifo_pop    = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_ISSUE: begin
`ifdef PR_BUS_MASTER_POLL_EN
        if (cur_poll_q && !poll_hit && !poll_last) begin
          // Another poll attempt next cycle on the same address.
          poll_cnt_d = poll_cnt_q + 1'b1;
          be_d       = be_q;
        end else begin
          state_d     = ST_RESP;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = cur_err_q || (cur_poll_q && !poll_hit);
          rsp_rdata_d = (cur_err_q || cur_wr_q) ? 32'h0 : rd_lane;
        end
`else
        state_d     = ST_RESP;
        rsp_vld_d   = 1'b1;
        rsp_err_d   = cur_err_q;
        rsp_rdata_d = (cur_err_q || cur_wr_q) ? 32'h0 : rd_lane;
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_vld_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
          load        = !fifo_empty;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head and set up the bus registers for the ISSUE cycle.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = ST_ISSUE;
      cur_wr_d   = head.wr;
      cur_size_d = head.size;
      cur_lane_d = head.addr[1:0];
      cur_err_d  = misaligned(head.size, head.addr[1:0]);
      wr_d       = head.wr && !cur_err_d;
      be_d       = cur_err_d ? 4'b0000 : be_gen(head.size, head.addr[1:0]);
      if (!cur_err_d) begin
        praddr_d = {head.addr[31:2], 2'b00};
        prwd_d   = lane_replicate(head.size, head.wdata);
      end
`ifdef PR_BUS_MASTER_POLL_EN
      cur_poll_d = head.poll && !head.wr && !cur_err_d;
      cur_mask_d = head.mask;
      cur_val_d  = head.wdata;
      poll_cnt_d = '0;
`endif
    end
  end

  // FSM, bus and response registers; reset drops Wr/BE immediately.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      be_q        <= 4'b0000;
      praddr_q    <= 32'h0;
      prwd_q      <= 32'h0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      cur_wr_q    <= 1'b0;
      cur_err_q   <= 1'b0;
      cur_size_q  <= 2'd0;
      cur_lane_q  <= 2'd0;
`ifdef PR_BUS_MASTER_POLL_EN
      cur_poll_q  <= 1'b0;
      cur_mask_q  <= 32'h0;
      cur_val_q   <= 32'h0;
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      praddr_q    <= praddr_d;
      prwd_q      <= prwd_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cur_wr_q    <= cur_wr_d;
      cur_err_q   <= cur_err_d;
      cur_size_q  <= cur_size_d;
      cur_lane_q  <= cur_lane_d;
`ifdef PR_BUS_MASTER_POLL_EN
      cur_poll_q  <= cur_poll_d;
      cur_mask_q  <= cur_mask_d;
      cur_val_q   <= cur_val_d;
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_pr_bus_master.sv
// Directed bench for pr_bus_master: reset, latency, lanes, errors, FIFO full, reset mid-access, poll.
// Latency: checks cycle-exact against accept N -> bus N+2 -> response N+3.
// Backpressure: holds rsp_ready low to fill the FIFO, then drains in order.
module tb_pr_bus_master;
  localparam int POLL_N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  int   n_run = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   poll_sel = 0;
  int   poll_base = 0;
  logic [31:0] rd_val = 32'h0;

  pr_bus_master_if bus ();

  pr_bus_master #(
    .FIFO_DEPTH(4)
`ifdef PR_BUS_MASTER_POLL_EN
    , .POLL_MAX(POLL_N)
`endif
  ) dut (
    .clk  (clk),
    .RST  (rst_n),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Bridge model: plain read value, or a poll target that sets bit0 on the 3rd read (sel 1) or never (sel 2).
  assign bus.PrRD = (poll_sel == 0) ? rd_val :
                    (poll_sel == 1 && (rd_cnt - poll_base) >= 2) ? 32'h1 : 32'h0;

  // Count completed bus write strobes and read accesses.
  always @(posedge clk) begin
    if (bus.Wr) wr_cnt <= wr_cnt + 1;
    if (bus.BE != 4'b0000 && !bus.Wr) rd_cnt <= rd_cnt + 1;
  end

  task automatic push_cmd(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
    logic ok;
    ok = 1'b0;
    bus.cmd_wr = wr; bus.cmd_size = size; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1 within 40 cycles", bus.cmd_ready);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b, required 0", bus.cmd_ready); end
    n_run++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    n_run++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h, required 0", bus.rsp_rdata); end
    n_run++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b, required 0", bus.rsp_err); end
    n_run++; if (bus.PrAddr !== 32'h0) begin n_fail++; $display("FAIL rst_praddr: got %h, required 0", bus.PrAddr); end
    n_run++; if (bus.BE !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %h, required 0", bus.BE); end
    n_run++; if (bus.PrWD !== 32'h0) begin n_fail++; $display("FAIL rst_prwd: got %h, required 0", bus.PrWD); end
    n_run++; if (bus.Wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b, required 0", bus.Wr); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    #1;
    n_run++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b, required 1", bus.cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_word_write;
    int w0;
    w0 = wr_cnt;
    bus.rsp_ready = 1'b0;
    push_cmd(1'b1, 2'd2, 32'h0000_7F00, 32'h1234_5678);
    // cycle N+1: still idle on the bus, command buffered
    n_run++; if (bus.Wr !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ww_n1: Wr=%b busy=%b, required Wr=0 busy=1", bus.Wr, busy); end
    @(posedge clk); #1;
    // cycle N+2: the bus access
    n_run++; if (bus.Wr !== 1'b1) begin n_fail++; $display("FAIL ww_wr: got %b, required 1", bus.Wr); end
    n_run++; if (bus.BE !== 4'hF) begin n_fail++; $display("FAIL ww_be: got %h, required f", bus.BE); end
    n_run++; if (bus.PrAddr !== 32'h0000_7F00) begin n_fail++; $display("FAIL ww_addr: got %h, required 00007f00", bus.PrAddr); end
    n_run++; if (bus.PrWD !== 32'h1234_5678) begin n_fail++; $display("FAIL ww_wd: got %h, required 12345678", bus.PrWD); end
    n_run++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ww_rsp_early: got %b, required 0", bus.rsp_valid); end
    @(posedge clk); #1;
    // cycle N+3: response, bus strobes gone, address held
    n_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL ww_rsp: valid=%b err=%b rdata=%h, required 1 0 00000000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    n_run++; if (bus.Wr !== 1'b0 || bus.BE !== 4'h0 || bus.PrAddr !== 32'h0000_7F00) begin
      n_fail++; $display("FAIL ww_after: Wr=%b BE=%h PrAddr=%h, required 0 0 00007f00", bus.Wr, bus.BE, bus.PrAddr); end
    n_run++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL ww_pulses: got %0d, required 1", wr_cnt - w0); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_run++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ww_done: rsp_valid=%b busy=%b, required 0 0", bus.rsp_valid, busy); end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, prrd, paddr;
    logic [3:0]  be;
    logic [31:0] wd, rdata;
  } vec_t;

  task automatic test_lanes;
    vec_t lv[6];
    lv[0] = '{1'b0, 2'd0, 32'h7F13, 32'h0,      32'hAABBCCDD, 32'h7F10, 4'h8, 32'h0,      32'h0000_00AA};
    lv[1] = '{1'b0, 2'd1, 32'h7F12, 32'h0,      32'hAABBCCDD, 32'h7F10, 4'hC, 32'h0,      32'h0000_AABB};
    lv[2] = '{1'b0, 2'd0, 32'h7F10, 32'h0,      32'hAABBCCDD, 32'h7F10, 4'h1, 32'h0,      32'h0000_00DD};
    lv[3] = '{1'b1, 2'd0, 32'h7F02, 32'h5A,     32'h0,        32'h7F00, 4'h4, 32'h5A5A5A5A, 32'h0};
    lv[4] = '{1'b1, 2'd1, 32'h7F02, 32'hFFFF1234, 32'h0,      32'h7F00, 4'hC, 32'h12341234, 32'h0};
    lv[5] = '{1'b0, 2'd2, 32'h7F04, 32'h0,      32'hAABBCCDD, 32'h7F04, 4'hF, 32'h0,      32'hAABBCCDD};
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_val = lv[i].prrd;
      push_cmd(lv[i].wr, lv[i].size, lv[i].addr, lv[i].wdata);
      @(posedge clk); #1;
      n_run++; if (bus.Wr !== lv[i].wr || bus.BE !== lv[i].be || bus.PrAddr !== lv[i].paddr) begin
        n_fail++; $display("FAIL lane%0d_bus: Wr=%b BE=%h PrAddr=%h, required %b %h %h", i, bus.Wr, bus.BE, bus.PrAddr, lv[i].wr, lv[i].be, lv[i].paddr); end
      if (lv[i].wr) begin
        n_run++; if (bus.PrWD !== lv[i].wd) begin n_fail++; $display("FAIL lane%0d_wd: got %h, required %h", i, bus.PrWD, lv[i].wd); end
      end
      @(posedge clk); #1;
      n_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== lv[i].rdata) begin
        n_fail++; $display("FAIL lane%0d_rsp: valid=%b err=%b rdata=%h, required 1 0 %h", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, lv[i].rdata); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_errors;
    logic        e_wr[4];
    logic [1:0]  e_sz[4];
    logic [31:0] e_ad[4];
    int w0, r0;
    e_wr[0] = 1'b1; e_sz[0] = 2'd1; e_ad[0] = 32'h7F01;
    e_wr[1] = 1'b0; e_sz[1] = 2'd2; e_ad[1] = 32'h7F02;
    e_wr[2] = 1'b1; e_sz[2] = 2'd3; e_ad[2] = 32'h7F00;
    e_wr[3] = 1'b0; e_sz[3] = 2'd1; e_ad[3] = 32'h7F03;
    rd_val = 32'hAABBCCDD;
    w0 = wr_cnt; r0 = rd_cnt;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(e_wr[i], e_sz[i], e_ad[i], 32'hCAFE_F00D);
      @(posedge clk); #1;
      n_run++; if (bus.Wr !== 1'b0 || bus.BE !== 4'h0) begin
        n_fail++; $display("FAIL err%0d_bus: Wr=%b BE=%h, required 0 0", i, bus.Wr, bus.BE); end
      @(posedge clk); #1;
      n_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
        n_fail++; $display("FAIL err%0d_rsp: valid=%b err=%b rdata=%h, required 1 1 00000000", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
    n_run++; if (wr_cnt != w0 || rd_cnt != r0) begin
      n_fail++; $display("FAIL err_no_access: writes=%0d reads=%0d, required 0 0", wr_cnt - w0, rd_cnt - r0); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz[6];
    logic [31:0] ad[6], ex[6];
    int   k;
    logic acc, rhs, chs;
    sz[0] = 2'd0; ad[0] = 32'h100; ex[0] = 32'h11;
    sz[1] = 2'd0; ad[1] = 32'h101; ex[1] = 32'h22;
    sz[2] = 2'd0; ad[2] = 32'h102; ex[2] = 32'h33;
    sz[3] = 2'd0; ad[3] = 32'h103; ex[3] = 32'h44;
    sz[4] = 2'd1; ad[4] = 32'h102; ex[4] = 32'h4433;
    sz[5] = 2'd2; ad[5] = 32'h104; ex[5] = 32'h44332211;
    rd_val = 32'h44332211;
    bus.rsp_ready = 1'b0;
    // One command is held by the stalled FSM, so the 4-entry FIFO fills on the 5th push.
    for (int i = 0; i < 5; i++) push_cmd(1'b0, sz[i], ad[i], 32'h0);
    n_run++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bb_full: cmd_ready=%b, required 0", bus.cmd_ready); end
    bus.cmd_wr = 1'b0; bus.cmd_size = sz[5]; bus.cmd_addr = ad[5]; bus.cmd_wdata = 32'h0;
    bus.cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_run++; if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bb_stall: cmd_ready=%b busy=%b, required 0 1", bus.cmd_ready, busy); end
    bus.rsp_ready = 1'b1;
    k = 0; acc = 1'b0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      rhs = bus.rsp_valid;
      chs = bus.cmd_valid && bus.cmd_ready;
      if (rhs) begin
        n_run++; if (bus.rsp_rdata !== ex[k] || bus.rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL bb_rsp%0d: rdata=%h err=%b, required %h 0", k, bus.rsp_rdata, bus.rsp_err, ex[k]); end
        k++;
      end
      @(posedge clk); #1;
      if (chs) begin bus.cmd_valid = 1'b0; acc = 1'b1; end
    end
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    n_run++; if (k != 6 || !acc) begin n_fail++; $display("FAIL bb_count: responses=%0d accepted6=%b, required 6 1", k, acc); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bb_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid_access;
    int   w0;
    logic seen;
    bus.rsp_ready = 1'b0;
    w0 = wr_cnt;
    push_cmd(1'b1, 2'd2, 32'h7F20, 32'hDEADBEEF);
    push_cmd(1'b1, 2'd2, 32'h7F24, 32'h0BADF00D);
    // now in the ISSUE cycle of the first write, second one buffered
    n_run++; if (bus.Wr !== 1'b1) begin n_fail++; $display("FAIL rm_issue: Wr=%b, required 1", bus.Wr); end
    rst_n = 1'b0;
    #1;
    n_run++; if (bus.Wr !== 1'b0 || bus.BE !== 4'h0) begin n_fail++; $display("FAIL rm_async: Wr=%b BE=%h, required 0 0", bus.Wr, bus.BE); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_run++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_release: busy=%b rsp_valid=%b cmd_ready=%b, required 0 0 1", busy, bus.rsp_valid, bus.cmd_ready); end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || busy) seen = 1'b1;
    end
    n_run++; if (seen || wr_cnt != w0) begin
      n_fail++; $display("FAIL rm_stale: activity=%b writes=%0d, required 0 0", seen, wr_cnt - w0); end
  endtask

`ifdef PR_BUS_MASTER_POLL_EN
  task automatic test_poll;
    int c;
    bus.rsp_ready = 1'b0;
    bus.cmd_poll = 1'b1; bus.cmd_mask = 32'h1;
    poll_sel = 1; poll_base = rd_cnt;
    push_cmd(1'b0, 2'd2, 32'h200, 32'h1);
    c = 0;
    while (!bus.rsp_valid && c < 50) begin @(posedge clk); #1; c++; end
    n_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h1 || rd_cnt - poll_base != 3) begin
      n_fail++; $display("FAIL poll_hit: valid=%b err=%b rdata=%h reads=%0d, required 1 0 00000001 3", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, rd_cnt - poll_base); end
    bus.rsp_ready = 1'b1; @(posedge clk); #1; bus.rsp_ready = 1'b0;
    poll_sel = 2; poll_base = rd_cnt;
    push_cmd(1'b0, 2'd2, 32'h200, 32'h1);
    c = 0;
    while (!bus.rsp_valid && c < POLL_N + 50) begin @(posedge clk); #1; c++; end
    n_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || rd_cnt - poll_base != POLL_N) begin
      n_fail++; $display("FAIL poll_timeout: valid=%b err=%b rdata=%h reads=%0d, required 1 1 00000000 %0d", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, rd_cnt - poll_base, POLL_N); end
    bus.rsp_ready = 1'b1; @(posedge clk); #1; bus.rsp_ready = 1'b0;
    bus.cmd_poll = 1'b0; poll_sel = 0;
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_size = 2'd0;
    bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b0;
`ifdef PR_BUS_MASTER_POLL_EN
    bus.cmd_poll = 1'b0; bus.cmd_mask = 32'h0;
`endif
    test_reset();
    test_word_write();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
`ifdef PR_BUS_MASTER_POLL_EN
    test_poll();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
